// File: rtl/pps_pkg.sv
// Shared constants for the PPS receiver: state encodings, count width and default clock rate.
package pps_pkg;

   localparam int COUNT_W = 32;
   localparam int DEFAULT_CLOCK_RATE_HZ = 50_000_000;

   localparam logic [1:0] ST_HUNT    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

endpackage

// File: rtl/pps_sync.sv
// Multi-flop synchroniser for an asynchronous PPS line plus a registered rising-edge pulse.
module pps_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync;
   logic              last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         last <= 1'b0;
         rise <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         last <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~last;
      end
   end

endmodule

// File: rtl/pps_measure.sv
// PPS receiver: measures the period between synchronised rising edges and tracks lock/loss.
// Handshake: o_count is valid only in the cycle o_count_stb is high; there is no back-pressure.
module pps_measure
   import pps_pkg::*;
#(
   parameter int CLOCK_RATE_HZ = DEFAULT_CLOCK_RATE_HZ,
   parameter int TOLERANCE     = CLOCK_RATE_HZ / 1000,
   parameter int LOCK_COUNT    = 2,
   parameter int TIMEOUT       = CLOCK_RATE_HZ * 3 / 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_pps,
   output logic               o_tick,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_count_stb,
   output logic               o_err,
   output logic               o_missing,
   output logic               o_locked,
   output logic [1:0]         dbg_state
);

   localparam int GCNT_W = $clog2(LOCK_COUNT + 1);
   localparam logic [COUNT_W:0] HI_BOUND = (COUNT_W+1)'(CLOCK_RATE_HZ) + (COUNT_W+1)'(TOLERANCE);
   localparam logic [COUNT_W:0] LO_BOUND = (CLOCK_RATE_HZ > TOLERANCE) ?
                                           (COUNT_W+1)'(CLOCK_RATE_HZ - TOLERANCE) : '0;

   logic               edge_pulse;
   logic [1:0]         state, state_next;
   logic [COUNT_W-1:0] counter, counter_next;
   logic [GCNT_W-1:0]  good_cnt, good_cnt_next;
   logic [COUNT_W:0]   period;
   logic               good, timeout_hit;
   logic               stb_next, err_next, miss_next;

   pps_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (i_clk),
      .rst  (i_reset),
      .din  (i_pps),
      .rise (edge_pulse)
   );

   assign period      = {1'b0, counter} + 1'b1;
   assign good        = (period >= LO_BOUND) && (period <= HI_BOUND);
   assign timeout_hit = (counter == COUNT_W'(TIMEOUT - 1));
   assign dbg_state   = state;

   always_comb begin
      state_next    = state;
      good_cnt_next = good_cnt;
      counter_next  = counter + 1'b1;
      stb_next      = 1'b0;
      err_next      = 1'b0;
      miss_next     = 1'b0;
      case (state)
         ST_HUNT: begin
            counter_next = '0;
            if (edge_pulse) state_next = ST_MEASURE;
         end
         ST_MEASURE, ST_LOCKED: begin
            // An edge on the timeout cycle takes priority and is judged as a normal period.
            if (edge_pulse) begin
               counter_next = '0;
               stb_next     = 1'b1;
               if (good) begin
                  if (32'(good_cnt) + 32'd1 >= 32'(LOCK_COUNT)) begin
                     good_cnt_next = GCNT_W'(LOCK_COUNT);
                     state_next    = ST_LOCKED;
                  end else begin
                     good_cnt_next = good_cnt + 1'b1;
                  end
               end else begin
                  err_next      = 1'b1;
                  good_cnt_next = '0;
                  state_next    = ST_MEASURE;
               end
            end else if (timeout_hit) begin
               miss_next     = 1'b1;
               good_cnt_next = '0;
               counter_next  = '0;
               state_next    = ST_HUNT;
            end
         end
         default: begin
            counter_next = '0;
            state_next   = ST_HUNT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= ST_HUNT;
         counter     <= '0;
         good_cnt    <= '0;
         o_tick      <= 1'b0;
         o_count     <= '0;
         o_count_stb <= 1'b0;
         o_err       <= 1'b0;
         o_missing   <= 1'b0;
         o_locked    <= 1'b0;
      end else begin
         state       <= state_next;
         counter     <= counter_next;
         good_cnt    <= good_cnt_next;
         o_tick      <= edge_pulse;
         o_count_stb <= stb_next;
         o_err       <= err_next;
         o_missing   <= miss_next;
         o_locked    <= (state_next == ST_LOCKED);
         if (stb_next) o_count <= period[COUNT_W-1:0];
      end
   end

   a_counter_range: assert property (@(posedge i_clk) disable iff (i_reset)
      counter < COUNT_W'(TIMEOUT));
   a_good_cnt_range: assert property (@(posedge i_clk) disable iff (i_reset)
      32'(good_cnt) <= 32'(LOCK_COUNT));
   a_locked_state: assert property (@(posedge i_clk) disable iff (i_reset)
      o_locked == (state == ST_LOCKED));

endmodule

// File: tb/tb_pps_measure.sv
// Directed bench for pps_measure: PPS periods, tolerance edges, loss, glitches and reset.
module tb_pps_measure;

   logic        i_clk;
   logic        i_reset;
   logic        i_pps;
   logic        o_tick;
   logic [31:0] o_count;
   logic        o_count_stb;
   logic        o_err;
   logic        o_missing;
   logic        o_locked;
   logic [1:0]  dbg_state;

   // expected strobe entries: {err, locked, count}
   logic [33:0] exp_q[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tick_cnt = 0;
   int miss_cnt = 0;
   int err_cnt = 0;
   int last_tick_cyc = 0;
   logic tick_prev = 1'b0;

   pps_measure #(
      .CLOCK_RATE_HZ(1000),
      .TOLERANCE    (10),
      .LOCK_COUNT   (2),
      .TIMEOUT      (1500),
      .SYNC_STAGES  (2)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_pps      (i_pps),
      .o_tick     (o_tick),
      .o_count    (o_count),
      .o_count_stb(o_count_stb),
      .o_err      (o_err),
      .o_missing  (o_missing),
      .o_locked   (o_locked),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      forever begin
         @(posedge i_clk);
         cyc = cyc + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_stb(input int count, input logic err, input logic locked);
      exp_q.push_back({err, locked, 32'(count)});
   endtask

   // driver: one rise at the start, high for 'high' cycles, 'len' cycles in total
   task automatic drive_pps(input int high, input int len);
      for (int i = 0; i < len; i++) begin
         i_pps = (i < high);
         @(negedge i_clk);
      end
   endtask

   // scoreboard / monitor, sampled on the falling edge
   initial begin
      logic [33:0] e;
      forever begin
         @(negedge i_clk);
         if (!i_reset) begin
            if (o_tick) begin
               tick_cnt = tick_cnt + 1;
               check_eq("tick_width", 32'(tick_prev), 32'd0);
               last_tick_cyc = cyc;
            end
            tick_prev = o_tick;
            if (o_count_stb) begin
               if (exp_q.size() == 0) begin
                  check_eq("stb_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("count", o_count, e[31:0]);
                  check_eq("err_at_stb", 32'(o_err), 32'(e[33]));
                  check_eq("locked_at_stb", 32'(o_locked), 32'(e[32]));
               end
            end else if (o_err) begin
               check_eq("err_without_stb", 32'd1, 32'd0);
            end
            if (o_err) err_cnt = err_cnt + 1;
            if (o_missing) begin
               miss_cnt = miss_cnt + 1;
               check_eq("miss_gap", 32'(cyc - last_tick_cyc), 32'd1500);
               check_eq("miss_locked", 32'(o_locked), 32'd0);
            end
         end
      end
   end

   initial begin
      i_reset = 1'b1;
      i_pps   = 1'b0;
      repeat (2) @(negedge i_clk);
      check_eq("rst_tick", 32'(o_tick), 32'd0);
      check_eq("rst_count", o_count, 32'd0);
      check_eq("rst_stb", 32'(o_count_stb), 32'd0);
      check_eq("rst_err", 32'(o_err), 32'd0);
      check_eq("rst_missing", 32'(o_missing), 32'd0);
      check_eq("rst_locked", 32'(o_locked), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);

      // nominal periods: lock with the third edge's strobe
      expect_stb(1000, 1'b0, 1'b0);
      expect_stb(1000, 1'b0, 1'b1);
      expect_stb(1000, 1'b0, 1'b1);
      repeat (3) drive_pps(5, 1000);
      drive_pps(5, 1011);
      check_eq("t1_state", 32'(dbg_state), 32'd2);
      check_eq("t1_locked", 32'(o_locked), 32'd1);

      // one period just above tolerance, then relock
      expect_stb(1011, 1'b1, 1'b0);
      expect_stb(1000, 1'b0, 1'b0);
      expect_stb(1000, 1'b0, 1'b1);
      drive_pps(5, 1000);
      check_eq("t2_unlocked", 32'(o_locked), 32'd0);
      check_eq("t2_state", 32'(dbg_state), 32'd1);
      drive_pps(5, 1000);
      drive_pps(5, 990);

      // tolerance boundaries
      expect_stb(990, 1'b0, 1'b1);
      expect_stb(1010, 1'b0, 1'b1);
      expect_stb(989, 1'b1, 1'b0);
      expect_stb(1000, 1'b0, 1'b0);
      expect_stb(1000, 1'b0, 1'b1);
      drive_pps(5, 1010);
      drive_pps(5, 989);
      drive_pps(5, 1000);
      drive_pps(5, 1000);

      // loss of pulses while locked
      drive_pps(5, 1700);
      check_eq("t4_miss_cnt", 32'(miss_cnt), 32'd1);
      check_eq("t4_state", 32'(dbg_state), 32'd0);
      check_eq("t4_locked", 32'(o_locked), 32'd0);

      // long high levels, then a one-cycle low glitch
      expect_stb(1000, 1'b0, 1'b0);
      expect_stb(1000, 1'b0, 1'b1);
      expect_stb(1000, 1'b0, 1'b1);
      expect_stb(301, 1'b1, 1'b0);
      expect_stb(699, 1'b1, 1'b0);
      expect_stb(1000, 1'b0, 1'b0);
      drive_pps(600, 1000);
      drive_pps(600, 1000);
      drive_pps(600, 1000);
      drive_pps(300, 300);
      drive_pps(0, 1);
      drive_pps(299, 699);
      drive_pps(600, 1000);

      // reset 400 cycles into a measured period
      drive_pps(5, 400);
      check_eq("t5_ticks", 32'(tick_cnt), 32'd19);
      #2 i_reset = 1'b1;
      #1;
      check_eq("t6_count", o_count, 32'd0);
      check_eq("t6_locked", 32'(o_locked), 32'd0);
      check_eq("t6_state", 32'(dbg_state), 32'd0);
      check_eq("t6_stb", 32'(o_count_stb), 32'd0);
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      expect_stb(1000, 1'b0, 1'b0);
      drive_pps(5, 1000);
      check_eq("t6_hunt_exit", 32'(dbg_state), 32'd1);
      drive_pps(5, 100);
      repeat (10) @(negedge i_clk);

      check_eq("pending_stb", 32'(exp_q.size()), 32'd0);
      check_eq("tick_total", 32'(tick_cnt), 32'd21);
      check_eq("miss_total", 32'(miss_cnt), 32'd1);
      check_eq("err_total", 32'(err_cnt), 32'd4);
      check_eq("count_hold", o_count, 32'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
